// File: rtl/mips_ctrl_defines.sv
// Shared encodings for the multicycle MIPS main controller.
// States, aluOp codes, mux selects, opcodes and the control word.
package mips_ctrl_defines;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    IEXEC  = 4'd8,
    IWB    = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_ITYPE = 3'b011;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_XORI);
  endfunction

  function automatic logic is_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational control-word decode from state, opcode and mem_ready.
// Unused state encodings decode to an all-zero word.
module mips_ctrl_decode
  import mips_ctrl_defines::*;
(
  input  state_t     st,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      cw
);

  logic legal;

  always_comb begin
    legal = is_itype(opcode) || (opcode == OP_LW) ||
            (opcode == OP_SW) || (opcode == OP_RTYPE) ||
            (opcode == OP_BEQ) || (opcode == OP_BNE) ||
            (opcode == OP_J);
  end

  always_comb begin
    cw = '0;
    case (st)
      FETCH: begin
        cw.mem_req   = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        cw.pc_src    = PCSRC_ALU;
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      DECODE: begin
        cw.alu_src_b  = SRCB_IMMSH;
        cw.alu_op     = ALUOP_ADD;
        cw.illegal_op = !legal;
      end
      MEMADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        cw.mem_req = 1'b1;
        cw.i_or_d  = 1'b1;
      end
      MEMWR: begin
        cw.mem_req   = 1'b1;
        cw.mem_write = 1'b1;
        cw.i_or_d    = 1'b1;
      end
      MEMWB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      REXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALUOP_RTYPE;
      end
      RWB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      IEXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ITYPE;
        cw.zero_ext  = is_zext(opcode);
      end
      IWB: cw.reg_write = 1'b1;
      BRANCH: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALUOP_SUB;
        cw.pc_src    = PCSRC_ALUOUT;
        cw.branch_eq = (opcode == OP_BEQ);
        cw.branch_ne = (opcode == OP_BNE);
      end
      JUMP: begin
        cw.pc_write = 1'b1;
        cw.pc_src   = PCSRC_JUMP;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core.
// Holds the state register and next-state logic; outputs come from the decoder.
module mips_multicycle_ctrl
  import mips_ctrl_defines::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               branch_eq,
  output logic               branch_ne,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               zero_ext,
  output logic [2:0]         alu_op,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t cur, nxt;
  ctrl_t  cw, cw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) nxt = MEMADR;
        else if (opcode == OP_RTYPE)            nxt = REXEC;
        else if (opcode == OP_BEQ ||
                 opcode == OP_BNE)              nxt = BRANCH;
        else if (opcode == OP_J)                nxt = JUMP;
        else if (is_itype(opcode))              nxt = IEXEC;
        else                                    nxt = FETCH;
      end
      MEMADR: nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
      REXEC:  nxt = RWB;
      IEXEC:  nxt = IWB;
      default: nxt = FETCH;
    endcase
  end

  mips_ctrl_decode u_dec (
    .st        (cur),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .cw        (cw)
  );

  // Reset masks the word combinationally so writes stop the instant rst rises.
  assign cw_q = rst ? '0 : cw;

  assign mem_req    = cw_q.mem_req;
  assign mem_write  = cw_q.mem_write;
  assign i_or_d     = cw_q.i_or_d;
  assign ir_write   = cw_q.ir_write;
  assign pc_write   = cw_q.pc_write;
  assign branch_eq  = cw_q.branch_eq;
  assign branch_ne  = cw_q.branch_ne;
  assign pc_src     = cw_q.pc_src;
  assign alu_src_a  = cw_q.alu_src_a;
  assign alu_src_b  = cw_q.alu_src_b;
  assign zero_ext   = cw_q.zero_ext;
  assign alu_op     = cw_q.alu_op;
  assign reg_write  = cw_q.reg_write;
  assign reg_dst    = cw_q.reg_dst;
  assign mem_to_reg = cw_q.mem_to_reg;
  assign illegal_op = cw_q.illegal_op;
  assign state      = rst ? '0 : STATE_W'(cur);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for the multicycle MIPS control FSM.
// Inputs change 1ns after rising edges; outputs are sampled on falling edges.
module tb_mips_multicycle_ctrl;

  localparam int S_FETCH  = 0;
  localparam int S_DECODE = 1;
  localparam int S_MEMADR = 2;
  localparam int S_MEMRD  = 3;
  localparam int S_MEMWB  = 4;
  localparam int S_MEMWR  = 5;
  localparam int S_REXEC  = 6;
  localparam int S_RWB    = 7;
  localparam int S_IEXEC  = 8;
  localparam int S_IWB    = 9;
  localparam int S_BRANCH = 10;
  localparam int S_JUMP   = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_write, i_or_d, ir_write, pc_write;
  logic       branch_eq, branch_ne, alu_src_a, zero_ext;
  logic       reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  int errs = 0;
  int checks = 0;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .branch_eq  (branch_eq),
    .branch_ne  (branch_ne),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .zero_ext   (zero_ext),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt(input logic [5:0] op, input logic mr);
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = mr;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    opcode = 6'b100011;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_ir_write", 32'(ir_write), 0);
    chk("rst_alu_src_b", 32'(alu_src_b), 0);

    // lw, no waits: 5 cycles
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("lw_fetch_st", 32'(state), S_FETCH);
    chk("lw_fetch_irw", 32'(ir_write), 1);
    chk("lw_fetch_pcw", 32'(pc_write), 1);
    chk("lw_fetch_srcb", 32'(alu_src_b), 1);
    chk("lw_fetch_req", 32'(mem_req), 1);
    nxt(6'b100011, 1'b1);
    chk("lw_dec_st", 32'(state), S_DECODE);
    chk("lw_dec_srcb", 32'(alu_src_b), 3);
    nxt(6'b100011, 1'b1);
    chk("lw_adr_st", 32'(state), S_MEMADR);
    chk("lw_adr_srca", 32'(alu_src_a), 1);
    chk("lw_adr_srcb", 32'(alu_src_b), 2);
    nxt(6'b100011, 1'b1);
    chk("lw_rd_st", 32'(state), S_MEMRD);
    chk("lw_rd_iord", 32'(i_or_d), 1);
    chk("lw_rd_wr", 32'(mem_write), 0);
    nxt(6'b100011, 1'b1);
    chk("lw_wb_st", 32'(state), S_MEMWB);
    chk("lw_wb_regw", 32'(reg_write), 1);
    chk("lw_wb_m2r", 32'(mem_to_reg), 1);
    chk("lw_wb_dst", 32'(reg_dst), 0);

    // fetch stall of 3 cycles, then R-type
    for (int i = 0; i < 3; i++) begin
      nxt(6'b000000, 1'b0);
      chk("stall_st", 32'(state), S_FETCH);
      chk("stall_req", 32'(mem_req), 1);
      chk("stall_irw", 32'(ir_write), 0);
      chk("stall_pcw", 32'(pc_write), 0);
    end
    nxt(6'b000000, 1'b1);
    chk("stall_end_st", 32'(state), S_FETCH);
    chk("stall_end_irw", 32'(ir_write), 1);
    chk("stall_end_pcw", 32'(pc_write), 1);
    nxt(6'b000000, 1'b1);
    chk("r_dec_st", 32'(state), S_DECODE);
    nxt(6'b000000, 1'b1);
    chk("r_exec_st", 32'(state), S_REXEC);
    chk("r_exec_op", 32'(alu_op), 3'b010);
    chk("r_exec_srcb", 32'(alu_src_b), 0);
    chk("r_exec_srca", 32'(alu_src_a), 1);
    nxt(6'b000000, 1'b1);
    chk("r_wb_st", 32'(state), S_RWB);
    chk("r_wb_dst", 32'(reg_dst), 1);
    chk("r_wb_regw", 32'(reg_write), 1);
    chk("r_wb_m2r", 32'(mem_to_reg), 0);

    // addi then ori
    nxt(6'b001000, 1'b1);
    chk("addi_fetch_st", 32'(state), S_FETCH);
    nxt(6'b001000, 1'b1);
    nxt(6'b001000, 1'b1);
    chk("addi_exec_st", 32'(state), S_IEXEC);
    chk("addi_exec_op", 32'(alu_op), 3'b011);
    chk("addi_zext", 32'(zero_ext), 0);
    nxt(6'b001000, 1'b1);
    chk("addi_wb_st", 32'(state), S_IWB);
    chk("addi_wb_regw", 32'(reg_write), 1);
    chk("addi_wb_dst", 32'(reg_dst), 0);
    nxt(6'b001101, 1'b1);
    nxt(6'b001101, 1'b1);
    nxt(6'b001101, 1'b1);
    chk("ori_exec_st", 32'(state), S_IEXEC);
    chk("ori_exec_op", 32'(alu_op), 3'b011);
    chk("ori_zext", 32'(zero_ext), 1);
    nxt(6'b001101, 1'b1);
    chk("ori_wb_st", 32'(state), S_IWB);

    // beq then bne: 3 cycles each
    nxt(6'b000100, 1'b1);
    chk("beq_fetch_st", 32'(state), S_FETCH);
    nxt(6'b000100, 1'b1);
    nxt(6'b000100, 1'b1);
    chk("beq_br_st", 32'(state), S_BRANCH);
    chk("beq_op", 32'(alu_op), 3'b001);
    chk("beq_pcsrc", 32'(pc_src), 1);
    chk("beq_eq", 32'(branch_eq), 1);
    chk("beq_ne", 32'(branch_ne), 0);
    nxt(6'b000101, 1'b1);
    chk("bne_fetch_st", 32'(state), S_FETCH);
    nxt(6'b000101, 1'b1);
    nxt(6'b000101, 1'b1);
    chk("bne_br_st", 32'(state), S_BRANCH);
    chk("bne_pcsrc", 32'(pc_src), 1);
    chk("bne_eq", 32'(branch_eq), 0);
    chk("bne_ne", 32'(branch_ne), 1);

    // jump
    nxt(6'b000010, 1'b1);
    nxt(6'b000010, 1'b1);
    nxt(6'b000010, 1'b1);
    chk("j_st", 32'(state), S_JUMP);
    chk("j_pcw", 32'(pc_write), 1);
    chk("j_pcsrc", 32'(pc_src), 2);

    // illegal opcode: 2 cycles, one-cycle pulse
    nxt(6'b111111, 1'b1);
    chk("ill_fetch_st", 32'(state), S_FETCH);
    chk("ill_fetch_pulse", 32'(illegal_op), 0);
    nxt(6'b111111, 1'b1);
    chk("ill_dec_st", 32'(state), S_DECODE);
    chk("ill_dec_pulse", 32'(illegal_op), 1);
    nxt(6'b111111, 1'b1);
    chk("ill_back_st", 32'(state), S_FETCH);
    chk("ill_back_pulse", 32'(illegal_op), 0);

    // sw stalled in MEMWR, then reset mid-access
    nxt(6'b101011, 1'b1);
    chk("sw_dec_st", 32'(state), S_DECODE);
    nxt(6'b101011, 1'b0);
    chk("sw_adr_st", 32'(state), S_MEMADR);
    nxt(6'b101011, 1'b0);
    chk("sw_wr_st", 32'(state), S_MEMWR);
    chk("sw_wr_we", 32'(mem_write), 1);
    chk("sw_wr_iord", 32'(i_or_d), 1);
    nxt(6'b101011, 1'b0);
    chk("sw_wr_hold", 32'(state), S_MEMWR);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_we", 32'(mem_write), 0);
    chk("rst_mid_req", 32'(mem_req), 0);
    chk("rst_mid_st", 32'(state), S_FETCH);
    @(negedge clk);
    chk("rst_hold_we", 32'(mem_write), 0);
    chk("rst_hold_regw", 32'(reg_write), 0);
    chk("rst_hold_pcw", 32'(pc_write), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_st", 32'(state), S_FETCH);
    chk("post_rst_req", 32'(mem_req), 1);
    chk("post_rst_we", 32'(mem_write), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS core.
- Sequences one shared ALU (through aluCtrl), the IR, the PC, the register file and a unified instruction/data memory.
- Generates the 3-bit aluOp consumed by aluCtrl:
  - 000 add
  - 001 sub
  - 010 R-type, decoded by funct
  - 011 I-type, decoded by opcode
- Stalls on a memory ready handshake.

Parameters:
- STATE_W, 4, width of state register and debug port.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26]; valid from DECODE onward.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access active (FETCH, MEMRD, MEMWR).
- mem_write  output  1  write access (MEMWR only).
- i_or_d  output  1  0 = address from PC, 1 = address from ALUOut.
- ir_write  output  1  load IR.
- pc_write  output  1  unconditional PC load.
- branch_eq  output  1  PC load if ALU zero.
- branch_ne  output  1  PC load if ALU not zero.
- pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- alu_src_a  output  1  0 = PC, 1 = regA.
- alu_src_b  output  2  00 regB, 01 const 4, 10 sign/zero-ext imm, 11 ext imm<<2.
- zero_ext  output  1  immediate zero-extended (andi/ori/xori).
- alu_op  output  3  aluOp to aluCtrl.
- reg_write  output  1  register file write.
- reg_dst  output  1  0 = rt, 1 = rd.
- mem_to_reg  output  1  0 = ALUOut, 1 = MDR.
- illegal_op  output  1  one-cycle pulse on unsupported opcode.
- state  output  STATE_W  current state, debug.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH, JUMP.
- Reset (rst=1, asynchronous): state=FETCH; all outputs forced 0 while rst is high, including state-decoded ones. The first fetch begins in the cycle after rst falls.

State actions and transitions:
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00.
  - ir_write and pc_write equal mem_ready.
  - Stay while !mem_ready; go to DECODE when mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Next state by opcode:
  - lw 100011 / sw 101011 -> MEMADR
  - R-type 000000 -> REXEC
  - beq 000100 / bne 000101 -> BRANCH
  - j 000010 -> JUMP
  - addi 001000, slti 001010, andi 001100, ori 001101, xori 001110 -> IEXEC
  - anything else -> FETCH with illegal_op=1 for this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000, zero_ext=0. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, i_or_d=1. Hold until mem_ready, then go to MEMWB.
- MEMWR: mem_req=1, mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- REXEC: alu_src_a=1, alu_src_b=00, alu_op=010. Go to RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_op=011.
  - zero_ext=1 for andi/ori/xori; 0 for addi/slti.
  - Go to IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01.
  - branch_eq=1 if opcode=beq; branch_ne=1 if opcode=bne.
  - Go to FETCH.
- JUMP: pc_write=1, pc_src=10. Go to FETCH.

General rules:
- Unlisted outputs are 0 in every state. No output is X in any state.
- Latency with mem_ready=1: lw 5 cycles; sw, R-type, I-type 4; beq/bne and j 3; illegal 2.
- Each asserted wait cycle adds exactly 1 cycle per memory state.
- opcode is sampled only in DECODE, MEMADR, IEXEC and BRANCH. The IR is stable outside FETCH, so no opcode register is needed.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Reset mid-instruction: the FSM aborts immediately, with no partial writes after rst is asserted.
- An unreachable state encoding returns to FETCH on the next clock.

Decomposition:
- Shared package mips_ctrl_defines:
  - state encodings (4-bit)
  - aluOp constants ALUOP_ADD/SUB/RTYPE/ITYPE
  - pc_src and alu_src_b encodings
  - opcode constants
- One sub-module, mips_ctrl_decode: purely combinational (state, opcode, mem_ready) -> control word.
- The top module holds only the state register and the next-state logic.

Test Plan:
- lw (opcode 100011), mem_ready=1 throughout -> FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles.
  - MEMWB shows reg_write=1, mem_to_reg=1, reg_dst=0.
  - FETCH shows ir_write=pc_write=1, alu_src_b=01.
- FETCH with mem_ready low for 3 cycles -> state held in FETCH, mem_req=1, ir_write=pc_write=0.
  - On the 4th cycle mem_ready=1 gives ir_write=pc_write=1, then DECODE.
- addi (001000) then ori (001101) -> IEXEC alu_op=011 for both; zero_ext=0 then 1; IWB reg_write=1, reg_dst=0.
- R-type (000000) -> REXEC alu_op=010, alu_src_b=00; RWB reg_dst=1.
- beq (000100) then bne (000101) -> BRANCH alu_op=001, pc_src=01.
  - branch_eq=1/branch_ne=0 for beq, the reverse for bne; 3 cycles each.
- Opcode 111111 -> illegal_op pulses one cycle in DECODE, then FETCH.
- rst asserted mid-MEMWR -> mem_write drops in the same cycle and state=FETCH; no writes until rst deasserts.
